mem_dump_scanner: RTL and testbench
===================================

# mem_dump_scanner

Post-halt data-memory readout sequencer sitting directly downstream of the RV32I core. Once the core raises `hlt`, it takes ownership of the core's `test` / `test_addr` inspection path and walks a configured range of data-memory words. It captures each word from the core's `Result` output and streams it out as (address, data) beats on a valid/ready interface, for the UART/bench result consumer. It runs on the ungated system clock, so it keeps working while the core's clock is gated off.

## Interface
- `START_ADDR`, default 0: first byte address scanned; must be word-aligned.
- `N_WORDS`, default 64: number of 32-bit words scanned, 1..64; `START_ADDR + 4*(N_WORDS-1)` must be ≤ 255.
- `READ_LAT`, default 1: cycles `test_addr` is held before `Result` is sampled, 1..15.
- `clk` in, 1: system clock, ungated.
- `rst` in, 1: asynchronous, active-low reset.
- `start` in, 1: arm request, sampled only in IDLE or DONE.
- `hlt` in, 1: core halt flag.
- `Result` in, 32: core result bus, which carries the data-memory word while `test`=1.
- `test` out, 1: forces the core into word-read inspection mode.
- `test_addr` out, 8: byte address presented to the core.
- `dout_data` out, 32: captured word.
- `dout_addr` out, 8: byte address of `dout_data`.
- `dout_valid` out, 1: beat valid.
- `dout_ready` in, 1: consumer accepts the beat.
- `busy` out, 1: high in WAIT_HLT, READ and OUT.
- `done` out, 1: high in DONE.

## Operation
- FSM states: IDLE, WAIT_HLT, READ, OUT, DONE.
- **IDLE**: `start`=1 → WAIT_HLT.
- **DONE**: `start`=1 → WAIT_HLT. Otherwise the FSM stays in DONE.
- **WAIT_HLT**: while `hlt`=0, the FSM stays in WAIT_HLT. When `hlt`=1, on that edge:
  - go to READ;
  - `test`←1, `test_addr`←`START_ADDR`;
  - latency counter ← `READ_LAT`-1;
  - word counter ← 0.
  - WAIT_HLT always lasts at least one cycle, even if `hlt` is already high when `start` is sampled.
- **READ**: lasts exactly `READ_LAT` cycles; the counter decrements each cycle. On the edge ending the last READ cycle:
  - `dout_data`←`Result`, `dout_addr`←`test_addr`, `dout_valid`←1;
  - go to OUT.
- **OUT**: `dout_valid` stays at 1 and `dout_data`, `dout_addr`, `test_addr` are held stable until the edge where `dout_valid`&`dout_ready`=1. On that edge `dout_valid`←0, and then:
  - if word counter = `N_WORDS`-1: go to DONE, `test`←0, `test_addr`←0;
  - else: `test_addr`←`test_addr`+4, word counter +1, latency counter reload, go to READ.
- `test` is 1 in READ and OUT only, and 0 in every other state.
- `hlt` deasserting during READ/OUT is ignored; the scan completes.
- `start` while `busy`=1 is ignored.
- Address arithmetic is 8-bit. The parameter constraint guarantees no wrap. The word counter is 6 bits wide.

## Timing
- Reset (`rst`=0, asynchronous, takes effect immediately, including mid-scan):
  - state IDLE;
  - `test`=0, `test_addr`=0;
  - `dout_data`=0, `dout_addr`=0, `dout_valid`=0;
  - `busy`=0, `done`=0.
  - After reset release, the first `start` must be re-issued; no partial scan resumes.
- All outputs are registered; there is no combinational path from `dout_ready` or `Result` to any output.
- Per-word cost with `dout_ready` held at 1: `READ_LAT`+1 cycles.
- With `start` sampled at edge 0 and `hlt`=1:
  - `test` rises after edge 1;
  - beat k is valid after edge `1+READ_LAT+k*(READ_LAT+1)`;
  - DONE is reached after edge `1+N_WORDS*(READ_LAT+1)`.
- `busy` and `done` are decoded from registered state.
- `done` remains high until `start` or reset.

## Test plan
- **Basic scan**: `START_ADDR`=0, `N_WORDS`=4, `READ_LAT`=1; memory words 0x11111111, 0x22222222, 0x33333333, 0x44444444; `hlt`=1; `dout_ready`=1; `start` pulse at edge 0 →
  - `test` high edges 1..9;
  - beats (0x00,0x11111111), (0x04,…22), (0x08,…33), (0x0C,…44) valid after edges 2, 4, 6, 8;
  - `done`=1 after edge 9, with `test`=0.
- **Halt wait**: `start` pulsed with `hlt`=0 for 10 cycles → `busy`=1, `test`=0, no beats; after `hlt` rises, first beat arrives `READ_LAT`+1 cycles later.
- **Backpressure**: `dout_ready`=0 for 5 cycles during beat 1 → `dout_valid`, `dout_data`, `dout_addr` and `test_addr`=0x04 held constant; exactly 4 beats total, no duplicates, no drops.
- **Latency and end-of-range**: `READ_LAT`=3, `START_ADDR`=0xF0, `N_WORDS`=4 →
  - `Result` sampled only after 3 READ cycles;
  - addresses 0xF0, 0xF4, 0xF8, 0xFC;
  - no wrap to 0x00.
- **Reset mid-scan**: `rst` low during OUT of beat 2 → all outputs 0 immediately, state IDLE. A subsequent `start` rescans from `START_ADDR`.
- **Re-arm and ignored start**: `start` asserted while `busy`=1 is ignored. `start` in DONE → a second full scan with identical beats.

Source files
------------

// File: rtl/mem_dump_scanner.sv
// Post-halt data-memory readout: walks a word range through the core's
// test/test_addr path and streams (addr, data) beats over valid/ready.
module mem_dump_scanner #(
  parameter logic [7:0] START_ADDR = 8'd0,
  parameter int         N_WORDS    = 64,
  parameter int         READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hlt,
  input  logic [31:0] Result,
  output logic        test,
  output logic [7:0]  test_addr,
  output logic [31:0] dout_data,
  output logic [7:0]  dout_addr,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HLT,
    S_READ,
    S_OUT,
    S_DONE
  } state_e;

  localparam logic [3:0] LAT_LOAD  = 4'(READ_LAT - 1);
  localparam logic [5:0] LAST_WORD = 6'(N_WORDS - 1);

  state_e      state_q, state_d;
  logic        test_q, test_d;
  logic [7:0]  test_addr_q, test_addr_d;
  logic [31:0] dout_data_q, dout_data_d;
  logic [7:0]  dout_addr_q, dout_addr_d;
  logic        dout_valid_q, dout_valid_d;
  logic [3:0]  lat_q, lat_d;
  logic [5:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      test_q       <= 1'b0;
      test_addr_q  <= 8'd0;
      dout_data_q  <= 32'd0;
      dout_addr_q  <= 8'd0;
      dout_valid_q <= 1'b0;
      lat_q        <= 4'd0;
      cnt_q        <= 6'd0;
    end else begin
      state_q      <= state_d;
      test_q       <= test_d;
      test_addr_q  <= test_addr_d;
      dout_data_q  <= dout_data_d;
      dout_addr_q  <= dout_addr_d;
      dout_valid_q <= dout_valid_d;
      lat_q        <= lat_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    test_d       = test_q;
    test_addr_d  = test_addr_q;
    dout_data_d  = dout_data_q;
    dout_addr_d  = dout_addr_q;
    dout_valid_d = dout_valid_q;
    lat_d        = lat_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_WAIT_HLT;
      end
      S_WAIT_HLT: begin
        if (hlt) begin
          state_d     = S_READ;
          test_d      = 1'b1;
          test_addr_d = START_ADDR;
          lat_d       = LAT_LOAD;
          cnt_d       = 6'd0;
        end
      end
      S_READ: begin
        if (lat_q == 4'd0) begin
          dout_data_d  = Result;
          dout_addr_d  = test_addr_q;
          dout_valid_d = 1'b1;
          state_d      = S_OUT;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_OUT: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          if (cnt_q == LAST_WORD) begin
            state_d     = S_DONE;
            test_d      = 1'b0;
            test_addr_d = 8'd0;
          end else begin
            test_addr_d = test_addr_q + 8'd4;
            cnt_d       = cnt_q + 6'd1;
            lat_d       = LAT_LOAD;
            state_d     = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign test       = test_q;
  assign test_addr  = test_addr_q;
  assign dout_data  = dout_data_q;
  assign dout_addr  = dout_addr_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == S_WAIT_HLT) ||
                      (state_q == S_READ) ||
                      (state_q == S_OUT);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_dump_scanner.sv
// Bench for mem_dump_scanner: two parameterisations, cycle table for the
// basic scan, beat scoreboard, and hand-written multi-cycle corner cases.
module tb_mem_dump_scanner;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } beat_t;

  typedef struct packed {
    logic       start;
    logic       t;
    logic       v;
    logic [7:0] ta;
    logic       busy;
    logic       done;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hlt = 1'b0;
  logic ready = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        test_a, valid_a, busy_a, done_a;
  logic [7:0]  taddr_a, addr_a;
  logic [31:0] data_a, res_a;
  logic        test_b, valid_b, busy_b, done_b;
  logic [7:0]  taddr_b, addr_b;
  logic [31:0] data_b, res_b;

  int         age_b = 0;
  logic [7:0] prev_addr_b = 8'd0;
  logic       prev_test_b = 1'b0;

  int    tests = 0;
  int    fails = 0;
  beat_t q_a[$];
  beat_t q_b[$];
  row_t  tbl[10];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [7:0] a);
    return 32'h1111_1111 * (32'(a >> 2) + 32'd1);
  endfunction

  mem_dump_scanner #(
    .START_ADDR(8'h00), .N_WORDS(4), .READ_LAT(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .hlt(hlt),
    .Result(res_a), .test(test_a), .test_addr(taddr_a),
    .dout_data(data_a), .dout_addr(addr_a), .dout_valid(valid_a),
    .dout_ready(ready), .busy(busy_a), .done(done_a)
  );

  mem_dump_scanner #(
    .START_ADDR(8'hF0), .N_WORDS(4), .READ_LAT(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hlt(hlt),
    .Result(res_b), .test(test_b), .test_addr(taddr_b),
    .dout_data(data_b), .dout_addr(addr_b), .dout_valid(valid_b),
    .dout_ready(ready), .busy(busy_b), .done(done_b)
  );

  // Core model: memory data only appears once the address has settled
  assign res_a = test_a ? mem_word(taddr_a) : 32'hBAD0_BAD0;
  assign res_b = (test_b && age_b >= 2) ? mem_word(taddr_b)
                                        : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (test_b && prev_test_b && taddr_b == prev_addr_b)
      age_b <= age_b + 1;
    else
      age_b <= 0;
    prev_test_b <= test_b;
    prev_addr_b <= taddr_b;
  end

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    beat_t e;
    if (rst && valid_a && ready) begin
      if (q_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_beat_extra: got %h/%h expected none",
                 addr_a, data_a);
      end else begin
        e = q_a.pop_front();
        chk("a_beat", 64'({addr_a, data_a}), 64'({e.a, e.d}));
      end
    end
    if (rst && valid_b && ready) begin
      if (q_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_beat_extra: got %h/%h expected none",
                 addr_b, data_b);
      end else begin
        e = q_b.pop_front();
        chk("b_beat", 64'({addr_b, data_b}), 64'({e.a, e.d}));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_a();
    for (int i = 0; i < 4; i++)
      q_a.push_back({8'(4 * i), mem_word(8'(4 * i))});
  endtask

  task automatic push_b();
    for (int i = 0; i < 4; i++)
      q_b.push_back({8'(8'hF0 + 4 * i), mem_word(8'(8'hF0 + 4 * i))});
  endtask

  task automatic arm_a();
    push_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(string nm);
    int n = 0;
    while (!done_a && n < 100) begin
      tick();
      n++;
    end
    chk(nm, 64'({done_a, test_a}), 64'(2'b10));
    chk({nm, "_drain"}, 64'(q_a.size()), 64'd0);
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h0C, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", 64'({test_a, taddr_a, data_a, addr_a,
                      valid_a, busy_a, done_a}), 64'd0);
    chk("rst_b", 64'({test_b, taddr_b, data_b, addr_b,
                      valid_b, busy_b, done_b}), 64'd0);
    rst = 1'b1;
    hlt = 1'b1;
    ready = 1'b1;
    tick();

    // Basic scan, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      start_a = tbl[i].start;
      if (tbl[i].start) push_a();
      tick();
      chk($sformatf("basic_edge%0d", i),
          64'({test_a, valid_a, taddr_a, busy_a, done_a}),
          64'({tbl[i].t, tbl[i].v, tbl[i].ta, tbl[i].busy, tbl[i].done}));
    end
    start_a = 1'b0;
    chk("basic_drain", 64'(q_a.size()), 64'd0);

    // Halt wait, re-arm from DONE
    hlt = 1'b0;
    arm_a();
    repeat (10) begin
      tick();
      chk("hlt_wait", 64'({busy_a, test_a, valid_a}), 64'(3'b100));
    end
    hlt = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_a && n < 20);
    chk("hlt_latency", 64'(n), 64'd2);
    wait_done_a("hlt_done");

    // Backpressure on beat 1
    arm_a();
    n = 0;
    while (!(test_a && taddr_a == 8'h04) && n < 20) begin
      tick();
      n++;
    end
    ready = 1'b0;
    tick();
    chk("bp_first", 64'({valid_a, data_a, addr_a, taddr_a}),
        64'({1'b1, mem_word(8'h04), 8'h04, 8'h04}));
    repeat (5) begin
      tick();
      chk("bp_hold", 64'({valid_a, data_a, addr_a, taddr_a}),
          64'({1'b1, mem_word(8'h04), 8'h04, 8'h04}));
    end
    ready = 1'b1;
    wait_done_a("bp_done");

    // Start while busy is ignored; done holds
    arm_a();
    tick();
    tick();
    start_a = 1'b1;
    tick();
    tick();
    start_a = 1'b0;
    wait_done_a("ign_done");
    repeat (4) tick();
    chk("done_hold", 64'({done_a, busy_a, test_a}), 64'(3'b100));

    // Reset during OUT of beat 2
    arm_a();
    n = 0;
    while (!(valid_a && addr_a == 8'h08) && n < 30) begin
      tick();
      n++;
    end
    rst = 1'b0;
    #1;
    chk("rst_mid", 64'({test_a, taddr_a, data_a, addr_a,
                        valid_a, busy_a, done_a}), 64'd0);
    q_a.delete();
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("rst_no_resume", 64'({busy_a, test_a, valid_a, done_a}), 64'd0);
    arm_a();
    wait_done_a("rescan_done");

    // Long latency, top of address range
    push_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!valid_b && n < 40) begin
      tick();
      n++;
    end
    chk("b_first_beat_edge", 64'(n), 64'd4);
    while (!done_b && n < 60) begin
      tick();
      n++;
    end
    chk("b_done_edge", 64'(n), 64'd17);
    chk("b_done_state", 64'({done_b, test_b, taddr_b}), 64'(10'b10_0000_0000));
    chk("b_drain", 64'(q_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
